// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
package data_mem_arbiter_pkg;

    localparam int WORD_SIZE  = 19;
    localparam int ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE,
        CPU_OWN,
        DMA_OWN,
        DMA_LOCK
    } arb_state_t;

    typedef enum logic {
        REQ_CPU,
        REQ_DMA
    } req_id_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_SIZE-1:0]  wdata;
    } mem_cmd_t;

endpackage

// File: rtl/data_mem_arbiter_rd_return_pipe.sv
// Two-stage {valid, owner} pipeline matching the command register plus memory read latency.
module mem_rd_return_pipe
    import data_mem_arbiter_pkg::req_id_t;
    import data_mem_arbiter_pkg::REQ_CPU;
    import data_mem_arbiter_pkg::REQ_DMA;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    issue_valid,
    input  req_id_t issue_owner,
    output logic    cpu_rvalid,
    output logic    dma_rvalid
);

    logic    s1_valid;
    req_id_t s1_owner;
    logic    s2_valid;
    req_id_t s2_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_owner <= REQ_CPU;
            s2_valid <= 1'b0;
            s2_owner <= REQ_CPU;
        end else begin
            s1_valid <= issue_valid;
            s1_owner <= issue_owner;
            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
        end
    end

    assign cpu_rvalid = s2_valid && (s2_owner == REQ_CPU);
    assign dma_rvalid = s2_valid && (s2_owner == REQ_DMA);

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter between CPU and DMA for the single-port data memory,
// with a bounded DMA burst lock and registered command outputs.
module data_mem_arbiter
    import data_mem_arbiter_pkg::arb_state_t;
    import data_mem_arbiter_pkg::req_id_t;
    import data_mem_arbiter_pkg::IDLE;
    import data_mem_arbiter_pkg::CPU_OWN;
    import data_mem_arbiter_pkg::DMA_OWN;
    import data_mem_arbiter_pkg::DMA_LOCK;
    import data_mem_arbiter_pkg::REQ_CPU;
    import data_mem_arbiter_pkg::REQ_DMA;
#(
    parameter int WORD_SIZE  = data_mem_arbiter_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = data_mem_arbiter_pkg::ADDR_WIDTH,
    parameter int MAX_LOCK   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [WORD_SIZE-1:0]  dma_wdata,
    input  logic                  dma_lock,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [WORD_SIZE-1:0]  rdata,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata
);

    localparam int LOCK_W = $clog2(MAX_LOCK + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

    arb_state_t        state, state_next;
    req_id_t           last_grant, last_grant_next;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_next;
    logic              lock_hold;
    logic              issue_read;
    req_id_t           issue_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ_DMA;
            lock_cnt   <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            lock_cnt   <= lock_cnt_next;
        end
    end

    always_comb begin
        cpu_gnt         = 1'b0;
        dma_gnt         = 1'b0;
        state_next      = state;
        last_grant_next = last_grant;
        lock_cnt_next   = lock_cnt;
        lock_hold       = (state == DMA_LOCK) && (lock_cnt < LOCK_MAX);

        if (cpu_req && dma_req) begin
            if (lock_hold || last_grant == REQ_CPU) dma_gnt = 1'b1;
            else                                    cpu_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt = 1'b1;
        end

        if (cpu_gnt) begin
            state_next      = CPU_OWN;
            last_grant_next = REQ_CPU;
            lock_cnt_next   = '0;
        end else if (dma_gnt) begin
            state_next      = dma_lock ? DMA_LOCK : DMA_OWN;
            last_grant_next = REQ_DMA;
            // The grant that enters the lock counts, so a burst is at most MAX_LOCK grants.
            if (dma_lock && cpu_req && lock_cnt < LOCK_MAX)
                lock_cnt_next = lock_cnt + 1'b1;
        end else begin
            state_next = IDLE;
        end

        if (!dma_lock) lock_cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (cpu_gnt) begin
            mem_wr_en <= cpu_we;
            mem_rd_en <= !cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
        end else if (dma_gnt) begin
            mem_wr_en <= dma_we;
            mem_rd_en <= !dma_we;
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
        end else begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
        end
    end

    assign issue_read  = (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
    assign issue_owner = dma_gnt ? REQ_DMA : REQ_CPU;

    mem_rd_return_pipe u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_read),
        .issue_owner(issue_owner),
        .cpu_rvalid (cpu_rvalid),
        .dma_rvalid (dma_rvalid)
    );

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed scoreboard bench for data_mem_arbiter with a behavioural 1024-word memory.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [WORD_SIZE-1:0]  cpu_wdata;
    logic                  dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [WORD_SIZE-1:0]  dma_wdata;
    logic [WORD_SIZE-1:0]  rdata;
    logic                  mem_wr_en, mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;
    logic [WORD_SIZE-1:0]  mem_rdata;

    logic [WORD_SIZE-1:0]  mem [0:1023];

    typedef struct {
        logic                 dma;
        logic [WORD_SIZE-1:0] data;
        int                   due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    data_mem_arbiter #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MAX_LOCK  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_lock  (dma_lock),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .rdata     (rdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req  = 1'b0;
        dma_req  = 1'b0;
        dma_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_mem_wr_en", 32'(mem_wr_en), 0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_rvalids", {30'd0, cpu_rvalid, dma_rvalid}, 0);
        tick();
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every rvalid and checks global invariants.
    always @(negedge clk) begin
        check("one_hot_enables", 32'(mem_wr_en & mem_rd_en), 0);
        check("one_hot_gnt", 32'(cpu_gnt & dma_gnt), 0);
        if (cpu_rvalid || dma_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rvalid_owner", {30'd0, cpu_rvalid, dma_rvalid}, e.dma ? 32'd1 : 32'd2);
                check("rdata", 32'(rdata), 32'(e.data));
                check("rvalid_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        do_reset();

        // CPU only: write 0x005, then read it back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h005; cpu_wdata = 19'h1ABCD;
        @(negedge clk);
        check("cpu_wr_gnt", {30'd0, cpu_gnt, dma_gnt}, 2);
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        check("cpu_wr_en_t1", 32'(mem_wr_en), 1);
        check("cpu_wr_rd_en_t1", 32'(mem_rd_en), 0);
        check("cpu_wr_addr", 32'(mem_addr), 32'h005);
        check("cpu_wr_data", 32'(mem_wdata), 32'h1ABCD);
        check("cpu_rd_gnt", 32'(cpu_gnt), 1);
        sb.push_back('{dma: 1'b0, data: 19'h1ABCD, due: cyc + 2});
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_rd_en_t1", 32'(mem_rd_en), 1);
        repeat (3) tick();

        // Both requesting without lock: strict alternation starting with CPU.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_wdata = 19'h00111;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h020; dma_wdata = 19'h00222;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_gnt", {30'd0, cpu_gnt, dma_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
            tick();
        end
        idle_inputs();

        // Locked DMA burst: C, D x8, C, D x8, C.
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check("lock_gnt", {30'd0, cpu_gnt, dma_gnt},
                  (i == 0 || i == 9 || i == 18) ? 32'd2 : 32'd1);
            tick();
        end
        idle_inputs();
        tick();

        // DMA write then CPU read of the same address on the next cycle.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h3FF; dma_wdata = 19'h00042;
        @(negedge clk);
        check("b2b_dma_gnt", {30'd0, cpu_gnt, dma_gnt}, 1);
        tick();
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
        @(negedge clk);
        check("b2b_cpu_gnt", {30'd0, cpu_gnt, dma_gnt}, 2);
        sb.push_back('{dma: 1'b0, data: 19'h00042, due: cyc + 2});
        tick();
        cpu_req = 1'b0;
        repeat (4) tick();

        // Reset one cycle after a read grant drops the return.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        @(negedge clk);
        check("rst_mid_gnt", 32'(cpu_gnt), 1);
        tick();
        cpu_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rd_en_t1", 32'(mem_rd_en), 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_no_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 0);
        check("rst_mid_rd_en", 32'(mem_rd_en), 0);
        check("rst_mid_wr_en", 32'(mem_wr_en), 0);

        // Quiet period.
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("idle_enables", {30'd0, mem_wr_en, mem_rd_en}, 0);
            check("idle_gnts", {30'd0, cpu_gnt, dma_gnt}, 0);
            check("idle_state", 32'(dut.state), 32'(IDLE));
        end

        repeat (4) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
